rx_frame_trim_512: RTL

RX_FRAME_TRIM_512 -- requirements
Module: rx_frame_trim_512

---
 rtl/net_pkg.sv | 36 +++
 rtl/axi_stream.sv | 12 +
 rtl/axis_skid_reg_512.sv | 51 +++++
 rtl/rx_frame_trim_512.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared networking types and helpers: header constants, trim FSM states, beat record, byte-mask helpers.
// Pure declarations and combinational functions; no latency or backpressure of its own.
package net_pkg;

  localparam int          ETH_HDR_LEN    = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    ST_HEAD,
    ST_FWD,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  function automatic logic [63:0] keep_mask(input logic [6:0] n);
    if (n >= 7'd64) begin
      return {64{1'b1}};
    end
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] k);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'b0, k[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/axi_stream.sv
// 512-bit AXI-stream bundle with byte keep; byte 0 is data[7:0].
// Plain wires; handshake is valid && ready on the rising clock edge.
interface axi_stream;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic         valid;
  logic         ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/axis_skid_reg_512.sv
// Output register stage with one skid entry: 1-cycle latency, full rate while downstream is ready.
// up_ready comes straight from the skid-occupied flop, so it never depends on dn_ready combinationally.
module axis_skid_reg_512
  import net_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  up_valid,
  input  beat_t up_beat,
  output logic  up_ready,
  output logic  dn_valid,
  output beat_t dn_beat,
  input  logic  dn_ready
);

  beat_t out_q;
  beat_t skid_q;
  logic  out_vld;
  logic  skid_vld;
  logic  out_free;

  assign up_ready = ~skid_vld;
  assign dn_valid = out_vld;
  assign dn_beat  = out_q;
  assign out_free = ~out_vld | dn_ready;

  // The skid entry only fills when a beat arrives while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (up_valid) begin
        out_q   <= up_beat;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (up_valid && !skid_vld) begin
      skid_q   <= up_beat;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_trim_512.sv
// Strips Ethernet padding from RX IPv4 frames so each frame ends at 14 + IPv4 total length.
// 1-cycle registered output via skid stage; s_axis.ready is purely registered and held high while dropping.
module rx_frame_trim_512
  import net_pkg::*;
#(
  parameter int MIN_IP_LEN = 20
) (
  input  logic        net_clk,
  input  logic        sys_reset,
  axi_stream.slave    s_axis,
  axi_stream.master   m_axis,
  output logic [31:0] cnt_trimmed,
  output logic [31:0] cnt_truncated
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_IP_LEN);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] base;
  logic        trim_q;
  logic [16:0] len_q;
  logic        rdy_en;
  logic        skid_rdy;
  logic        fire;

  logic [15:0] etype;
  logic [15:0] ip_len;
  logic        hd_trim;
  logic [16:0] hd_len;
  logic        cur_trim;
  logic [16:0] cur_len;
  logic [6:0]  nbytes;
  logic [17:0] len_ext;
  logic [17:0] end_full;
  logic [17:0] end_keep;
  logic [16:0] rem;

  logic        up_valid;
  beat_t       up_beat;
  logic        dn_valid;
  beat_t       dn_beat;
  logic        inc_trim;
  logic        inc_trunc;

  assign s_axis.ready = rdy_en & ((state == ST_DROP) | skid_rdy);
  assign fire         = s_axis.valid & s_axis.ready;

  // Header fields are big-endian on the wire; byte 12 is the EtherType MSB.
  always_comb begin
    etype    = {s_axis.data[103:96], s_axis.data[111:104]};
    ip_len   = {s_axis.data[135:128], s_axis.data[143:136]};
    hd_trim  = (etype == ETHERTYPE_IPV4) && (ip_len >= MIN_LEN);
    hd_len   = 17'(ETH_HDR_LEN) + {1'b0, ip_len};
    cur_trim = (state == ST_HEAD) ? hd_trim : trim_q;
    cur_len  = (state == ST_HEAD) ? hd_len  : len_q;
    nbytes   = popcount64(s_axis.keep);
    len_ext  = {1'b0, cur_len};
    end_full = {2'b0, base} + 18'd64;
    end_keep = {2'b0, base} + {11'b0, nbytes};
    rem      = cur_len - {1'b0, base};
  end

  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= ST_HEAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    up_valid     = 1'b0;
    up_beat.data = s_axis.data;
    up_beat.keep = s_axis.keep;
    up_beat.last = s_axis.last;
    inc_trim     = 1'b0;
    inc_trunc    = 1'b0;
    if (fire) begin
      case (state)
        ST_HEAD, ST_FWD: begin
          up_valid = 1'b1;
          if (cur_trim && s_axis.last && (len_ext > end_keep)) begin
            // Frame ended before its declared length: pass as-is.
            inc_trunc = 1'b1;
            state_nxt = ST_HEAD;
          end else if (cur_trim && (len_ext <= end_full)) begin
            up_beat.keep = keep_mask(rem[6:0]);
            up_beat.last = 1'b1;
            if (s_axis.last) begin
              inc_trim  = (rem < {10'b0, nbytes});
              state_nxt = ST_HEAD;
            end else begin
              inc_trim  = 1'b1;
              state_nxt = ST_DROP;
            end
          end else begin
            state_nxt = s_axis.last ? ST_HEAD : ST_FWD;
          end
        end
        ST_DROP: begin
          if (s_axis.last) begin
            state_nxt = ST_HEAD;
          end
        end
        default: state_nxt = ST_HEAD;
      endcase
    end
  end

  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      base          <= '0;
      trim_q        <= 1'b0;
      len_q         <= '0;
      rdy_en        <= 1'b0;
      cnt_trimmed   <= '0;
      cnt_truncated <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (fire) begin
        base <= (state_nxt == ST_HEAD) ? 16'd0 : base + 16'd64;
        if (state == ST_HEAD) begin
          trim_q <= hd_trim;
          len_q  <= hd_len;
        end
        if (inc_trim) begin
          cnt_trimmed <= cnt_trimmed + 32'd1;
        end
        if (inc_trunc) begin
          cnt_truncated <= cnt_truncated + 32'd1;
        end
      end
    end
  end

  axis_skid_reg_512 u_out (
    .clk      (net_clk),
    .rst      (sys_reset),
    .up_valid (up_valid),
    .up_beat  (up_beat),
    .up_ready (skid_rdy),
    .dn_valid (dn_valid),
    .dn_beat  (dn_beat),
    .dn_ready (m_axis.ready)
  );

  assign m_axis.valid = dn_valid;
  assign m_axis.data  = dn_beat.data;
  assign m_axis.keep  = dn_beat.keep;
  assign m_axis.last  = dn_beat.last;

endmodule
